// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types, widths and field positions for the fetch stage.
// Contents: opcode / register-code / fetch-state enums, instruction field
// bit positions, and is_illegal_op() used when ILLEGAL_OP_TRAP_EN is defined.
package cpu_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 5;

    localparam int OP_MSB      = 15;
    localparam int OP_LSB      = 12;
    localparam int REG_MSB     = 11;
    localparam int REG_LSB     = 8;
    localparam int VAL_MSB     = 7;
    localparam int VAL_LSB     = 0;
    localparam int JMP_TGT_MSB = 7;
    localparam int JMP_TGT_LSB = 3;

    typedef enum logic [3:0] {
        ADD = 4'd0, SUB, OR, AND, XOR, NOT, ST, LD,
        NOP = 4'b1010,
        JMP = 4'b1111
    } opcode_e;

    typedef enum logic [3:0] {
        R0 = 4'd0, R1 = 4'd1, R2 = 4'd2, R3 = 4'd3,
        ID = 4'd4,
        DM0 = 4'd12, DM1 = 4'd13, DM2 = 4'd14, DM3 = 4'd15
    } reg_code_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Opcodes with no defined meaning: 8, 9 and B..E.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return op inside {4'h8, 4'h9, [4'hB:4'hE]};
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: program-memory bus plus decoded-instruction handshake.
// Signals: pm_addr/pm_data (combinational program-memory read),
// instr_valid/instr_ready handshake, op_code/reg_code/value/pc fields.
// master = fetch stage, slave = memory + execute side.
interface fetch_unit_if;
    import cpu_pkg::*;
    logic [ADDR_WIDTH-1:0] pm_addr;
    logic [DATA_WIDTH-1:0] pm_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [3:0]            op_code;
    logic [3:0]            reg_code;
    logic [7:0]            value;
    logic [ADDR_WIDTH-1:0] pc;

    modport master (
        output pm_addr, instr_valid, op_code, reg_code, value, pc,
        input  pm_data, instr_ready
    );
    modport slave (
        input  pm_addr, instr_valid, op_code, reg_code, value, pc,
        output pm_data, instr_ready
    );
endinterface

// File: rtl/fetch_unit_instr_fields.sv
// instr_fields: combinational split of an instruction word into its fields.
// Ports: i_word (instruction) -> o_op, o_reg, o_val, o_is_jmp,
// o_jmp_target, o_is_illegal.
module instr_fields
    import cpu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_word,
    output logic [3:0]            o_op,
    output logic [3:0]            o_reg,
    output logic [7:0]            o_val,
    output logic                  o_is_jmp,
    output logic [ADDR_WIDTH-1:0] o_jmp_target,
    output logic                  o_is_illegal
);
    assign o_op         = i_word[OP_MSB:OP_LSB];
    assign o_reg        = i_word[REG_MSB:REG_LSB];
    assign o_val        = i_word[VAL_MSB:VAL_LSB];
    assign o_is_jmp     = o_op == JMP;
    assign o_jmp_target = i_word[JMP_TGT_MSB:JMP_TGT_LSB];
    assign o_is_illegal = is_illegal_op(o_op);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with in-stage zero-bubble JMP.
// Ports: i_clk, i_rst_n (async active-low), i_en (run enable),
// bus (fetch_unit_if.master: program memory + decoded instruction
// handshake), o_trap (sticky illegal-opcode flag).
// Optional: define ILLEGAL_OP_TRAP_EN to trap on illegal opcodes and halt.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    fetch_unit_if.master bus,
    output logic         o_trap
);
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] r_fpc;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic                  r_trap;
    logic [3:0]            r_op;
    logic [3:0]            r_reg;
    logic [7:0]            r_val;
    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [3:0]            w_op;
    logic [3:0]            w_reg;
    logic [7:0]            w_val;
    logic                  w_is_jmp;
    logic [ADDR_WIDTH-1:0] w_jmp_tgt;
    logic                  w_is_illegal;
    logic                  w_capture;
    logic                  w_trap_hit;
    logic [ADDR_WIDTH-1:0] w_fpc_next;

    instr_fields u_fields (
        .i_word       (bus.pm_data),
        .o_op         (w_op),
        .o_reg        (w_reg),
        .o_val        (w_val),
        .o_is_jmp     (w_is_jmp),
        .o_jmp_target (w_jmp_tgt),
        .o_is_illegal (w_is_illegal)
    );

    // A capture waits until any held instruction is accepted, so a trap
    // never discards a pending instruction.
    always_comb begin
        w_capture    = i_en && r_state == RUN && (!r_valid || bus.instr_ready);
        w_trap_hit   = TRAP_EN && w_capture && w_is_illegal;
        w_state_next = w_trap_hit ? HALT : r_state;
        w_fpc_next   = w_is_jmp ? w_jmp_tgt : r_fpc + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= RUN;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fpc   <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_trap  <= 1'b0;
            r_op    <= '0;
            r_reg   <= '0;
            r_val   <= '0;
        end else if (w_trap_hit) begin
            r_pc    <= r_fpc;
            r_trap  <= 1'b1;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_op    <= w_op;
            r_reg   <= w_reg;
            r_val   <= w_val;
            r_pc    <= r_fpc;
            r_valid <= 1'b1;
            r_fpc   <= w_fpc_next;
        end else if (r_valid && bus.instr_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.pm_addr     = r_fpc;
    assign bus.instr_valid = r_valid;
    assign bus.op_code     = r_op;
    assign bus.reg_code    = r_reg;
    assign bus.value       = r_val;
    assign bus.pc          = r_pc;
    assign o_trap          = r_trap;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: drives the program-memory address, captures each 16-bit instruction word and splits it into opcode, register code and value fields. Presents each decoded instruction to the execute stage over a valid/ready handshake. Resolves JMP in-stage by redirecting the program counter, with zero bubble.

## Interface
- DATA_WIDTH, 16, instruction word width
- ADDR_WIDTH, 5, program-memory address width (32 words)
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- EN  in  1  run enable; low blocks new captures
- PM_ADDR  out  ADDR_WIDTH  address to program memory (combinational read)
- PM_DATA  in  DATA_WIDTH  instruction word from program memory, valid in the same cycle
- INSTR_VALID  out  1  decoded instruction outputs are valid
- INSTR_READY  in  1  execute stage accepts the instruction
- OP_CODE  out  4  PM_DATA[15:12] of the held instruction
- REG_CODE  out  4  PM_DATA[11:8]
- VALUE  out  8  PM_DATA[7:0]; for JMP, [7:3] is the target and [2:0] is reserved
- PC  out  ADDR_WIDTH  address of the held instruction
- TRAP  out  1  sticky illegal-opcode flag

## Operation
- Internal fetch pointer `fpc` drives PM_ADDR.
- Capture condition: EN && state==RUN && (!INSTR_VALID || INSTR_READY).
- On capture:
  - OP_CODE, REG_CODE and VALUE are loaded from PM_DATA.
  - PC is loaded from `fpc`.
  - INSTR_VALID is set to 1.
- Next `fpc` after a capture:
  - If PM_DATA[15:12]==4'b1111 (JMP), `fpc` = PM_DATA[7:3].
  - Otherwise `fpc` = `fpc`+1, modulo 32 (31 wraps to 0).
- JMP and NOP (4'b1010) are forwarded downstream like any other instruction. Execute treats both as no-ops.
- JMP to its own address loops indefinitely. This is legal.
- Acceptance without capture: if INSTR_VALID && INSTR_READY and the capture condition is false, INSTR_VALID clears to 0. The field outputs hold their last values.
- While INSTR_VALID && !INSTR_READY, all outputs and `fpc` are frozen.
- States:
  - RUN: normal fetch.
  - HALT: no further captures. Entered only through the trap path. Exited only by reset.

## Timing
- Reset values (asynchronous, take effect immediately, including mid-stall): `fpc`=0, PM_ADDR=0, PC=0, INSTR_VALID=0, OP_CODE=0, REG_CODE=0, VALUE=0, TRAP=0, state=RUN.
- Latency: the word at `fpc` is visible on the outputs directly after the capturing edge, i.e. one cycle from PM_ADDR to decoded output.
- Throughput: one instruction per cycle while EN=1 and INSTR_READY=1, including across JMP.
- Handshake: INSTR_VALID never drops without acceptance. Outputs are stable while valid and not ready.
- EN low while valid and not ready: the held instruction stays presented until accepted, then INSTR_VALID goes to 0.

## Configuration
- ILLEGAL_OP_TRAP_EN defined:
  - Illegal opcodes are 4'b1000, 4'b1001 and 4'b1011 through 4'b1110.
  - An illegal opcode meeting the capture condition is not forwarded.
  - On that edge, PC is loaded with the offending address, TRAP is set to 1 (sticky), state moves to HALT, and INSTR_VALID goes to 0.
  - Capture only happens once any prior instruction has been accepted, so a pending instruction is never dropped.
- ILLEGAL_OP_TRAP_EN undefined:
  - All opcodes are forwarded unchanged.
  - TRAP is tied to 0 and the HALT state is unreachable.
  - The TRAP port is always present.

## Structure
- Shared package `cpu_pkg` contains:
  - opcode enum: ADD=0, SUB, OR, AND, XOR, NOT, ST, LD, NOP=4'b1010, JMP=4'b1111
  - reg_code enum: R0–R3=0–3, ID=4, DM0–DM3=12–15
  - field position constants: OP[15:12], REG[11:8], VAL[7:0], JMP_TGT[7:3]
  - fetch state enum
- One combinational sub-module, `instr_fields`: splits a word into its fields and produces is_jmp, jmp_target and is_illegal.

## Test plan
- Reset release, EN=1, READY=1, ROM[0]=16'h0105 -> first edge gives OP_CODE=0, REG_CODE=1, VALUE=8'h05, PC=0, INSTR_VALID=1; next PC=1.
- Hold READY=0 for 3 cycles while valid -> outputs and PM_ADDR unchanged; on READY=1 the next word is captured on that edge.
- ROM[2]=16'hF028 (JMP, target 5) -> JMP presented with PC=2; next instruction presented has PC=5, with no bubble.
- ROM filled with NOP, straight-line run -> PC sequence 30, 31, 0, 1.
- ROM[3]=16'h8000 with ILLEGAL_OP_TRAP_EN -> after PC=2 is accepted, TRAP=1, PC=3, INSTR_VALID=0, remains halted. Without the macro -> OP_CODE=4'h8 forwarded and TRAP=0.
- Assert RST_N low mid-stall with INSTR_VALID=1 -> INSTR_VALID=0, PM_ADDR=0, all fields 0 immediately, without waiting for CLK.
